// File: rtl/polyvec_pointwise_acc_stream_pkg.sv
// Shared constants and types for the polyvec pointwise multiply-accumulate stream.
// Holds the Dilithium modulus, its Montgomery inverse and the controller state encoding.
package polyvec_pointwise_acc_stream_pkg;

    localparam int N     = 256;
    localparam int LOG2N = 8;

    localparam logic signed [31:0] Q    = 32'sd8380417;
    localparam logic signed [31:0] QINV = 32'sd58728449;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    typedef logic [LOG2N-1:0] coef_idx_t;
    typedef logic [2:0]       poly_idx_t;

endpackage

// File: rtl/polyvec_pointwise_acc_stream_if.sv
// Coefficient-pair input stream and accumulated-coefficient output stream.
// The slave modport is the accumulator's view; the master modport is its neighbours' view.
interface polyvec_pointwise_acc_stream_if;
    import polyvec_pointwise_acc_stream_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] a_coef;
    logic signed [31:0] b_coef;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_coef;
    coef_idx_t          out_idx;

    modport master (
        output in_valid, a_coef, b_coef, out_ready,
        input  in_ready, out_valid, out_coef, out_idx
    );

    modport slave (
        input  in_valid, a_coef, b_coef, out_ready,
        output in_ready, out_valid, out_coef, out_idx
    );

endinterface

// File: rtl/polyvec_pointwise_acc_stream_mont.sv
// Combinational signed Montgomery reduction: returns p * 2^-32 mod Q in (-Q, Q)
// for any |p| < Q * 2^31.
module polyvec_pointwise_acc_stream_mont
    import polyvec_pointwise_acc_stream_pkg::*;
(
    input  logic signed [63:0] i_p,
    output logic signed [31:0] o_t
);

    logic        [31:0] w_t32;
    logic signed [63:0] w_tq;

    // Low 32 bits of p*QINV, reinterpreted as signed, cancel the low word of p.
    assign w_t32 = i_p[31:0] * $unsigned(QINV);
    assign w_tq  = 64'($signed(w_t32)) * 64'(Q);
    assign o_t   = 32'((i_p - w_tq) >>> 32);

endmodule

// File: rtl/polyvec_pointwise_acc_stream.sv
// Streaming out[j] = sum_i mont(a_i[j]*b_i[j]) over L polynomials: FSM, index counters,
// a 3-stage stall-able pipeline and an N-entry accumulator that is read and written at one index.
module polyvec_pointwise_acc_stream
    import polyvec_pointwise_acc_stream_pkg::*;
#(
    parameter int L = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    polyvec_pointwise_acc_stream_if.slave bus
);

    localparam poly_idx_t LAST_POLY = poly_idx_t'(L - 1);
    localparam coef_idx_t LAST_COEF = coef_idx_t'(N - 1);

    state_t             r_state, w_next;
    coef_idx_t          r_coef;
    poly_idx_t          r_poly;

    logic               r_s1_valid, r_s2_valid, r_s3_valid;
    logic signed [63:0] r_s1_p;
    logic signed [31:0] r_s2_t, r_s3_sum;
    coef_idx_t          r_s1_idx, r_s2_idx, r_s3_idx;
    poly_idx_t          r_s1_poly, r_s2_poly;

    logic signed [31:0] r_acc [N];

    logic               w_advance, w_accept, w_last_pair, w_drained;
    logic signed [31:0] w_mont, w_sum;

    assign w_advance   = !r_s3_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && (r_state == ACC) && w_advance;
    assign w_last_pair = (r_coef == LAST_COEF) && (r_poly == LAST_POLY);
    // The pipeline is empty after this edge: earlier stages idle and S3 idle or handing off now.
    assign w_drained   = !r_s1_valid && !r_s2_valid && (!r_s3_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus.in_ready = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = ACC;
            end
            ACC: begin
                bus.in_ready = w_advance;
                if (bus.in_valid && w_advance && w_last_pair) w_next = DRAIN;
            end
            DRAIN: begin
                if (w_drained) w_next = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) begin
            r_coef <= '0;
            r_poly <= '0;
        end else if (w_accept) begin
            r_coef <= r_coef + 1'b1;
            if (r_coef == LAST_COEF) r_poly <= (r_poly == LAST_POLY) ? '0 : r_poly + 1'b1;
        end
    end

    polyvec_pointwise_acc_stream_mont u_mont (
        .i_p (r_s1_p),
        .o_t (w_mont)
    );

    assign w_sum = (r_s2_poly == '0) ? r_s2_t : r_acc[r_s2_idx] + r_s2_t;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_idx   <= '0;
            r_s1_poly  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_t     <= '0;
            r_s2_idx   <= '0;
            r_s2_poly  <= '0;
            r_s3_valid <= 1'b0;
            r_s3_sum   <= '0;
            r_s3_idx   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_accept;
            r_s1_p     <= 64'(bus.a_coef) * 64'(bus.b_coef);
            r_s1_idx   <= r_coef;
            r_s1_poly  <= r_poly;
            r_s2_valid <= r_s1_valid;
            r_s2_t     <= w_mont;
            r_s2_idx   <= r_s1_idx;
            r_s2_poly  <= r_s1_poly;
            r_s3_valid <= r_s2_valid && (r_s2_poly == LAST_POLY);
            r_s3_sum   <= w_sum;
            r_s3_idx   <= r_s2_idx;
        end
    end

    // Index j is revisited N cycles later, so a read-before-write RAM needs no bypass.
    always_ff @(posedge clk) begin
        if (w_advance && r_s2_valid && r_s2_poly != LAST_POLY) r_acc[r_s2_idx] <= w_sum;
    end

    assign bus.out_valid = r_s3_valid;
    assign bus.out_coef  = r_s3_sum;
    assign bus.out_idx   = r_s3_idx;

endmodule

// File: tb/tb_polyvec_pointwise_acc_stream.sv
// Randomised self-checking bench: drives an L=4 and an L=1 instance through a shared
// stimulus path and compares every output handshake with a plain-arithmetic reference.
module tb_polyvec_pointwise_acc_stream;
    import polyvec_pointwise_acc_stream_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    polyvec_pointwise_acc_stream_if if4 ();
    polyvec_pointwise_acc_stream_if if1 ();

    logic               start4, start1, busy4, busy1, done4, done1;
    logic               useL1;
    logic               inValid, outReady, startReq;
    logic signed [31:0] aIn, bIn;

    assign if4.in_valid  = inValid & ~useL1;
    assign if1.in_valid  = inValid & useL1;
    assign if4.a_coef    = aIn;
    assign if1.a_coef    = aIn;
    assign if4.b_coef    = bIn;
    assign if1.b_coef    = bIn;
    assign if4.out_ready = outReady;
    assign if1.out_ready = outReady;
    assign start4        = startReq & ~useL1;
    assign start1        = startReq & useL1;

    polyvec_pointwise_acc_stream #(.L(4)) dutL4 (
        .clk     (clk),
        .rst     (rst),
        .i_start (start4),
        .o_busy  (busy4),
        .o_done  (done4),
        .bus     (if4.slave)
    );

    polyvec_pointwise_acc_stream #(.L(1)) dutL1 (
        .clk     (clk),
        .rst     (rst),
        .i_start (start1),
        .o_busy  (busy1),
        .o_done  (done1),
        .bus     (if1.slave)
    );

    logic               obsInReady, obsValid, obsBusy, obsDone;
    logic signed [31:0] obsCoef;
    logic [7:0]         obsIdx;
    assign obsInReady = useL1 ? if1.in_ready  : if4.in_ready;
    assign obsValid   = useL1 ? if1.out_valid : if4.out_valid;
    assign obsCoef    = useL1 ? if1.out_coef  : if4.out_coef;
    assign obsIdx     = useL1 ? if1.out_idx   : if4.out_idx;
    assign obsBusy    = useL1 ? busy1 : busy4;
    assign obsDone    = useL1 ? done1 : done4;

    int testsRun = 0, testsFailed = 0;
    int cycleCnt = 0;
    int aMem [4][N];
    int bMem [4][N];
    int expOut [N];
    int curL = 4;
    int pairsAccepted, outCount, doneCount, nextIdx;
    int firstLastPassCycle, lastHsCycle;
    bit monitorOn = 0, checkLatency = 0, firstOutSeen, stalledPrev;
    logic signed [31:0] heldCoef;
    logic [7:0]         heldIdx;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Reference: Montgomery reduction by definition, t = (p - m*Q) / 2^32 with m = p*Q^-1 mod 2^32.
    function automatic int montModel(input longint p);
        longint m;
        m = longint'(int'(p * longint'(QINV)));
        return int'((p - m * longint'(Q)) >>> 32);
    endfunction

    function automatic void computeExpected(input int numPoly);
        for (int j = 0; j < N; j++) begin
            int s = 0;
            for (int i = 0; i < numPoly; i++)
                s += montModel(longint'(aMem[i][j]) * longint'(bMem[i][j]));
            expOut[j] = s;
        end
    endfunction

    // Output checker: every handshake against the reference, stall stability, done timing.
    always @(negedge clk) begin
        if (!rst && monitorOn) begin
            if (stalledPrev) begin
                checkOutput("stall_valid_held", obsValid, 1);
                checkOutput("stall_coef_held", obsCoef, heldCoef);
                checkOutput("stall_idx_held", obsIdx, heldIdx);
            end
            stalledPrev = 0;
            if (obsValid) begin
                if (!firstOutSeen) begin
                    firstOutSeen = 1;
                    checkOutput("no_early_output", (pairsAccepted > (curL - 1) * N) ? 1 : 0, 1);
                    if (checkLatency) checkOutput("first_out_latency", cycleCnt - firstLastPassCycle, 3);
                end
                if (outReady) begin
                    checkOutput("out_idx", obsIdx, nextIdx);
                    checkOutput("out_coef", obsCoef, expOut[obsIdx]);
                    nextIdx++;
                    outCount++;
                    lastHsCycle = cycleCnt;
                end else begin
                    stalledPrev = 1;
                    heldCoef    = obsCoef;
                    heldIdx     = obsIdx;
                end
            end
            if (obsDone) begin
                doneCount++;
                checkOutput("outputs_before_done", outCount, N);
                checkOutput("done_latency", cycleCnt - lastHsCycle, 1);
            end
        end
    end

    // One accumulation run; resetAtPair >= 0 aborts with rst once that many pairs were taken.
    task automatic applyStimulus(input int numPoly, input bit l1, input bit randReady,
                                 input int resetAtPair, input int startGlitchPair);
        int  budget = 0;
        bit  took;
        useL1 = l1;
        curL  = numPoly;
        computeExpected(numPoly);
        pairsAccepted = 0; outCount = 0; doneCount = 0; nextIdx = 0;
        firstOutSeen = 0; stalledPrev = 0; lastHsCycle = 0; firstLastPassCycle = 0;
        monitorOn = 1;
        inValid = 1; aIn = aMem[0][0]; bIn = bMem[0][0]; outReady = 1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("in_ready_idle", obsInReady, 0);
            @(posedge clk); #1;
        end
        startReq = 1;
        @(posedge clk); #1;
        startReq = 0;
        while (pairsAccepted < numPoly * N && budget < 20000) begin
            inValid  = ($urandom_range(0, 3) != 0);
            aIn      = aMem[pairsAccepted / N][pairsAccepted % N];
            bIn      = bMem[pairsAccepted / N][pairsAccepted % N];
            outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            startReq = (pairsAccepted == startGlitchPair);
            @(negedge clk);
            took = inValid && obsInReady;
            if (took && pairsAccepted == (numPoly - 1) * N) firstLastPassCycle = cycleCnt;
            @(posedge clk); #1;
            if (took) pairsAccepted++;
            budget++;
            if (pairsAccepted == resetAtPair) begin
                rst = 1; inValid = 0; startReq = 0;
                repeat (2) @(posedge clk);
                #1;
                rst = 0;
                @(negedge clk);
                checkOutput("abort_busy", obsBusy, 0);
                checkOutput("abort_out_valid", obsValid, 0);
                checkOutput("abort_in_ready", obsInReady, 0);
                checkOutput("abort_no_done", doneCount, 0);
                monitorOn = 0;
                return;
            end
        end
        inValid = 0; startReq = 0;
        while (doneCount == 0 && budget < 20000) begin
            outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("run_within_budget", (budget < 20000) ? 1 : 0, 1);
        checkOutput("outputs_total", outCount, N);
        @(negedge clk);
        checkOutput("done_single_pulse", obsDone, 0);
        checkOutput("idle_after_done", obsBusy, 0);
        checkOutput("done_count", doneCount, 1);
        monitorOn = 0;
    endtask

    task automatic fillConst(input int pa, input int a, input int b);
        for (int j = 0; j < N; j++) begin
            aMem[pa][j] = a;
            bMem[pa][j] = b;
        end
    endtask

    initial begin
        rst = 1; useL1 = 0; inValid = 0; outReady = 0; startReq = 0; aIn = 0; bIn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy4, 0);
        checkOutput("reset_done", done4, 0);
        checkOutput("reset_out_valid", if4.out_valid, 0);
        checkOutput("reset_in_ready", if4.in_ready, 0);
        checkOutput("reset_out_coef", if4.out_coef, 0);
        checkOutput("reset_out_idx", if4.out_idx, 0);
        checkOutput("reset_l1_busy", busy1, 0);
        @(posedge clk); #1;
        rst = 0;

        checkOutput("model_mont_pos", montModel(64'sd4294967296), 1);
        checkOutput("model_mont_neg", montModel(-64'sd4294967296), -1);
        checkOutput("model_mont_zero", montModel(0), 0);
        for (int k = 0; k < 4; k++) begin
            longint p;
            int     t;
            p = longint'($signed($urandom_range(0, 2 * 8380417 - 2)) - 8380416) *
                longint'($signed($urandom_range(0, 2 * 8380417 - 2)) - 8380416);
            t = montModel(p);
            checkOutput("model_mont_congruence", ((longint'(t) <<< 32) - p) % longint'(Q), 0);
            checkOutput("model_mont_range", (t > -8380417 && t < 8380417) ? 1 : 0, 1);
        end

        fillConst(0, 65536, 65536);
        computeExpected(1);
        checkOutput("model_t1", expOut[17], 1);
        applyStimulus(1, 1, 0, -1, -1);

        for (int i = 0; i < 4; i++) fillConst(i, 65536, 65536);
        computeExpected(4);
        checkOutput("model_t2", expOut[200], 4);
        checkLatency = 1;
        applyStimulus(4, 0, 0, -1, -1);
        checkLatency = 0;

        fillConst(0, 65536, 65536);
        fillConst(1, -65536, 65536);
        fillConst(2, 0, 12345);
        fillConst(3, 0, -777);
        checkOutput("model_t3_poly1", montModel(longint'(-65536) * 65536), -1);
        computeExpected(4);
        checkOutput("model_t3", expOut[3], 0);
        applyStimulus(4, 0, 1, -1, -1);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < N; j++) begin
                aMem[i][j] = $signed($urandom_range(0, 2 * 8380417 - 2)) - 8380416;
                bMem[i][j] = $signed($urandom_range(0, 2 * 8380417 - 2)) - 8380416;
            end
        applyStimulus(4, 0, 1, -1, 300);

        for (int i = 0; i < 4; i++) fillConst(i, 65536, 65536);
        applyStimulus(4, 0, 1, 2 * N + 100, -1);
        applyStimulus(4, 0, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
